ram_access_arbiter: RTL



---
 rtl/ram_access_arbiter_pkg.sv | 14 +
 rtl/ram_access_arbiter_rr.sv | 39 +++
 rtl/ram_access_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ram_access_arbiter_pkg.sv
// Shared types and constants for the two-client RAM access arbiter.
// No logic; imported by the arbiter top and its round-robin grant block.
package ram_access_arbiter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam int NUM_CLIENTS = 2;
    localparam int CLIENT_ID_W = 1;
    localparam int RD_LATENCY  = 2;

endpackage

// File: rtl/ram_access_arbiter_rr.sv
// Two-input round-robin grant, combinational; en masks all grants.
// Latency 0; the last-grant pointer moves only when a grant is given (valid is implied).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        // gnt is only ever set for a valid requester, so any grant is a transfer
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one simple-dual-port RAM between two clients after a zero-fill pass.
// Read latency 2 cycles from grant; one grant per cycle; no response backpressure.
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  init_done,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_wr_en,
    output logic                  ram_wr_clk_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    state_e state_q, state_d;
    // extra MSB marks "every address written"; the pass then spends one cycle handing over
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [RD_LATENCY-1:0]                  tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0][CLIENT_ID_W-1:0] tag_id_q, tag_id_d;

    logic                   arb_en;
    logic [1:0]             gnt;
    logic [CLIENT_ID_W-1:0] sel;
    logic                   rd_issue;

    assign arb_en = (state_q == ST_SERVE);

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req_valid),
        .gnt (gnt)
    );

    assign sel = gnt[1];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rd_issue  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (!clr_cnt_q[ADDR_WIDTH]) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
                    wr_data_d = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (gnt != 2'b00) begin
                    if (req_we[sel]) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel ? req_addr1 : req_addr0;
                        wr_data_d = sel ? req_wdata1 : req_wdata0;
                    end else begin
                        rd_addr_d = sel ? req_addr1 : req_addr0;
                        rd_issue  = 1'b1;
                    end
                end
                // a command granted alongside clear_req still lands ahead of the first clear write
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        tag_vld_d = {tag_vld_q[RD_LATENCY-2:0], rd_issue};
        tag_id_d  = {tag_id_q[RD_LATENCY-2:0], sel};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (tag_vld_q[RD_LATENCY-1]) begin
            rsp_valid[tag_id_q[RD_LATENCY-1]] = 1'b1;
        end
    end

    assign init_done     = (state_q == ST_SERVE);
    assign req_ready     = gnt;
    assign rsp_data      = ram_rd_data;
    assign ram_wr_en     = wr_en_q;
    assign ram_wr_clk_en = wr_en_q;
    assign ram_wr_addr   = wr_addr_q;
    assign ram_wr_data   = wr_data_q;
    assign ram_rd_addr   = rd_addr_q;

endmodule
